// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port among fetch, load/store and loader
module mem_port_arbiter #(
  parameter int N            = 32,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req_i,
  input  logic [2:0]          we_i,
  input  logic [3*ADDR_W-1:0] addr_i,
  input  logic [3*N-1:0]      wdata_i,
  output logic [2:0]          gnt_o,
  output logic [2:0]          err_o,
  output logic [2:0]          rvalid_o,
  output logic [N-1:0]        rdata_o,
  output logic                busy_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [N-1:0]        mem_wr_data_o,
  output logic                mem_wr_ena_o,
  input  logic [N-1:0]        mem_rd_data_i
);
  typedef enum logic {READY, WAIT} state_t;
  state_t                       state_q, state_d;
  logic [1:0]                   rr_ptr_q, rr_ptr_d, c0, c1, c2, sel;
  logic [2:0]                   cnt_q, cnt_d;
  logic [READ_LATENCY-1:0]      vld_q, vld_d;
  logic [READ_LATENCY-1:0][1:0] id_q, id_d;
  logic [ADDR_W-1:0]            a_sel;
  logic [N-1:0]                 w_sel;
  logic                         grant, aligned, rd_issue;
  always_comb begin
    c0 = rr_ptr_q;
    c1 = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
    c2 = (rr_ptr_q == 2'd0) ? 2'd2 : rr_ptr_q - 2'd1;
    sel = req_i[c0] ? c0 : req_i[c1] ? c1 : c2;
    a_sel = addr_i[sel*ADDR_W +: ADDR_W];
    w_sel = wdata_i[sel*N +: N];
    grant = (state_q == READY) && (|req_i);
    aligned = (a_sel[1:0] == 2'b00);
    gnt_o = grant ? (3'b001 << sel) : 3'b000;
    err_o = aligned ? 3'b000 : gnt_o;
    mem_addr_o = grant ? a_sel : '0;
    mem_wr_data_o = grant ? w_sel : '0;
    mem_wr_ena_o = grant & we_i[sel] & aligned;
    rd_issue = grant & ~we_i[sel] & aligned;
    rr_ptr_d = grant ? ((sel == 2'd2) ? 2'd0 : sel + 2'd1) : rr_ptr_q;
    // Counter is loaded with READ_LATENCY-1 so READY is re-entered exactly at T+READ_LATENCY
    state_d = (state_q == WAIT) ? ((cnt_q == 3'd1) ? READY : WAIT)
                                : ((rd_issue && READ_LATENCY > 1) ? WAIT : READY);
    cnt_d = (state_q == WAIT) ? cnt_q - 3'd1 : 3'(READ_LATENCY - 1);
    vld_d[0] = rd_issue;
    id_d[0] = sel;
    for (int j = 1; j < READ_LATENCY; j++) begin
      vld_d[j] = vld_q[j-1];
      id_d[j] = id_q[j-1];
    end
    rvalid_o = vld_q[READ_LATENCY-1] ? (3'b001 << id_q[READ_LATENCY-1]) : 3'b000;
    rdata_o = mem_rd_data_i;
    busy_o = (state_q == WAIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= READY;
      rr_ptr_q <= 2'd0;
      cnt_q <= 3'd0;
      vld_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      id_q <= id_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of a latency-1 and a latency-3 arbiter instance
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we;
  logic [95:0] addr, wdata;
  logic [31:0] rd_q;
  logic [2:0]  g1, e1, v1, g3, e3, v3;
  logic [31:0] rdat1, rdat3, ma1, ma3, wd1, wd3;
  logic        b1, b3, we1, we3;
  logic [31:0] mem [0:255];
  int          n_assert = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.N(32), .ADDR_W(32), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(g1), .err_o(e1), .rvalid_o(v1), .rdata_o(rdat1), .busy_o(b1),
    .mem_addr_o(ma1), .mem_wr_data_o(wd1), .mem_wr_ena_o(we1), .mem_rd_data_i(rd_q));
  mem_port_arbiter #(.N(32), .ADDR_W(32), .READ_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(g3), .err_o(e3), .rvalid_o(v3), .rdata_o(rdat3), .busy_o(b3),
    .mem_addr_o(ma3), .mem_wr_data_o(wd3), .mem_wr_ena_o(we3), .mem_rd_data_i(rd_q));
  // single-cycle synchronous memory driven by the latency-1 instance
  always @(posedge clk) begin
    if (rst) mem[64] <= 32'hDEADBEEF;
    else if (we1) mem[ma1[9:2]] <= wd1;
    rd_q <= mem[ma1[9:2]];
  end
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    req = 3'b000;
    tick;
    tick;
    rst = 1'b0;
  endtask
  initial begin
    logic [2:0] seq [0:3];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
    we = 3'b000; addr = '0; wdata = '0;
    do_reset;
    #1;
    chk("rst_gnt", {61'd0, g1}, 64'd0);
    chk("rst_err", {61'd0, e1}, 64'd0);
    chk("rst_rvalid", {61'd0, v1 | v3}, 64'd0);
    chk("rst_busy", {62'd0, b1, b3}, 64'd0);
    chk("rst_mem", {ma1, wd1}, 64'd0);
    chk("rst_wr_ena", {63'd0, we1}, 64'd0);
    // single read from requester 0
    req = 3'b001; addr[31:0] = 32'h100;
    #1;
    chk("rd_gnt", {61'd0, g1}, 64'd1);
    chk("rd_addr", {32'd0, ma1}, 64'h100);
    chk("rd_wr_ena", {63'd0, we1}, 64'd0);
    tick;
    req = 3'b000;
    #1;
    chk("rd_rvalid", {61'd0, v1}, 64'd1);
    chk("rd_rdata", {32'd0, rdat1}, 64'hDEADBEEF);
    chk("rd_busy_l1", {63'd0, b1}, 64'd0);
    // all three requesting reads, round robin
    do_reset;
    addr = {32'h8, 32'h4, 32'h0}; req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_gnt", {61'd0, g1}, {61'd0, seq[k]});
      chk("rr_rvalid", {61'd0, v1}, (k == 0) ? 64'd0 : {61'd0, seq[k-1]});
      tick;
    end
    req = 3'b000;
    #1;
    chk("rr_last_rvalid", {61'd0, v1}, 64'd1);
    chk("rr_idle_gnt", {61'd0, g1}, 64'd0);
    // misaligned write from requester 1 (rr_ptr is 1 here)
    req = 3'b010; we = 3'b010; addr[63:32] = 32'h202; wdata[63:32] = 32'h55;
    #1;
    chk("mis_gnt", {61'd0, g1}, 64'b010);
    chk("mis_err", {61'd0, e1}, 64'b010);
    chk("mis_wr_ena", {63'd0, we1}, 64'd0);
    tick;
    #1;
    chk("mis_rvalid", {61'd0, v1}, 64'd0);
    // rr_ptr must now be 2: requester 2 wins over 0
    req = 3'b101; we = 3'b100; addr[31:0] = 32'h0; addr[95:64] = 32'h40; wdata[95:64] = 32'h1;
    #1;
    chk("wr1_gnt", {61'd0, g1}, 64'b100);
    chk("wr1_ena", {63'd0, we1}, 64'd1);
    chk("wr1_mem", {ma1, wd1}, {32'h40, 32'h1});
    tick;
    req = 3'b100; addr[95:64] = 32'h44; wdata[95:64] = 32'h2;
    #1;
    chk("wr2_gnt", {61'd0, g1}, 64'b100);
    chk("wr2_mem", {31'd0, we1, ma1}, {31'd1, 32'h44});
    tick;
    we = 3'b000; addr[95:64] = 32'h40;
    #1;
    chk("rb1_gnt", {61'd0, g1}, 64'b100);
    tick;
    addr[95:64] = 32'h44;
    #1;
    chk("rb1_rvalid", {61'd0, v1}, 64'b100);
    chk("rb1_rdata", {32'd0, rdat1}, 64'd1);
    chk("rb2_gnt", {61'd0, g1}, 64'b100);
    tick;
    req = 3'b000;
    #1;
    chk("rb2_rdata", {29'd0, v1, rdat1}, {29'd4, 32'd2});
    // latency 3: read from 0 then queued write from 1
    do_reset;
    req = 3'b011; we = 3'b010; addr[31:0] = 32'h10; addr[63:32] = 32'h20; wdata[63:32] = 32'h77;
    #1;
    chk("l3_gnt0", {61'd0, g3}, 64'b001);
    chk("l3_busy0", {63'd0, b3}, 64'd0);
    tick;
    req = 3'b010;
    for (int k = 1; k < 3; k++) begin
      #1;
      chk("l3_wait_gnt", {61'd0, g3}, 64'd0);
      chk("l3_wait_busy", {63'd0, b3}, 64'd1);
      chk("l3_wait_mem", {31'd0, we3, ma3}, 64'd0);
      chk("l3_wait_rvalid", {61'd0, v3}, 64'd0);
      tick;
    end
    #1;
    chk("l3_gnt1", {61'd0, g3}, 64'b010);
    chk("l3_wr_ena", {63'd0, we3}, 64'd1);
    chk("l3_rvalid", {61'd0, v3}, 64'b001);
    chk("l3_busy3", {63'd0, b3}, 64'd0);
    tick;
    req = 3'b000;
    #1;
    chk("l3_after", {58'd0, g3, v3}, 64'd0);
    // reset during a latency-3 read
    do_reset;
    we = 3'b000; req = 3'b001;
    #1;
    chk("rr3_gnt", {61'd0, g3}, 64'b001);
    tick;
    req = 3'b000; rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr3_no_rvalid", {60'd0, b3, v3}, 64'd0);
      tick;
    end
    req = 3'b111; addr = {32'h8, 32'h4, 32'h0};
    #1;
    chk("rr3_first_gnt", {61'd0, g3}, 64'b001);
    tick;
    req = 3'b000;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
